// File: rtl/sqrt_rr_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_rr_share_ctrl
//  Purpose  : Round-robin controller that time-shares one external
//             combinational approximate square-root core (16-bit radicand in,
//             8-bit root out) among NUM_REQ requesters. An issue register
//             drives the core's radicand and a response register captures
//             the root, tagged with the ID of the requester that issued it.
//  Ports    :
//    clk        in   1            system clock, rising edge
//    rst_n      in   1            synchronous, active-low reset
//    req_valid  in   NUM_REQ      per-requester operand valid
//    req_data   in   16*NUM_REQ   per-requester radicand, slice i = [16i+15:16i]
//    req_ready  out  NUM_REQ      one-hot grant/accept (combinational)
//    sq_r       out  16           registered radicand to the sqrt core
//    sq_q       in   8            root from the sqrt core (function of sq_r)
//    rsp_valid  out  1            result valid
//    rsp_ready  in   1            downstream accepts result
//    rsp_data   out  8            root
//    rsp_id     out  ID_W         requester that issued the operand
//    grant_cnt  out  32           total accepted requests, wraps mod 2^32
//  Revision : 1.0  initial release
// ============================================================================
module sqrt_rr_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [15:0]          sq_r,
  input  logic [7:0]           sq_q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          grant_cnt
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic            r_op_valid;
  logic [ID_W-1:0] r_op_id;
  logic [15:0]     r_sq_r;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [7:0]      r_rsp_data;
  logic [ID_W-1:0] r_ptr;
  logic [31:0]     r_grant_cnt;

  // --------------------------------------------------------------------------
  // Pipeline advance conditions
  // --------------------------------------------------------------------------
  logic w_out_adv;
  logic w_iss_adv;

  // The response register may load whenever it is empty or being drained;
  // the issue register may load whenever it is empty or moving forward.
  assign w_out_adv = !r_rsp_valid || rsp_ready;
  assign w_iss_adv = !r_op_valid || w_out_adv;

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  logic            w_found;
  logic [ID_W-1:0] w_win;
  logic [15:0]     w_win_data;
  logic            w_accept;

  // Scan offsets from the largest down to zero so that the last hit, which is
  // the one that sticks, is the requester closest to (at or after) r_ptr.
  always_comb begin : p_arb
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (v_idx == i)) begin
          w_found = 1'b1;
          w_win   = ID_W'(i);
        end
      end
    end
  end

  assign w_accept = w_found && w_iss_adv;

  // Operand slice of the winner; constant-index select keeps the mux clean.
  always_comb begin : p_win_data
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(w_win) == i) begin
        w_win_data = req_data[16*i +: 16];
      end
    end
  end

  // Grant is forced low during reset so no requester believes it was served
  // by an edge that the registers are about to ignore.
  always_comb begin : p_ready
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && w_accept && (int'(w_win) == i);
    end
  end

  // Next pointer: one past the winner, wrapping at NUM_REQ (which need not be
  // a power of two, so the ID_W-bit increment alone is not enough).
  logic [ID_W-1:0] w_ptr_next;

  always_comb begin : p_ptr_next
    if (int'(w_win) == NUM_REQ - 1) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_win + ID_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Issue stage: holds the radicand presented to the core. During a stall
  // nothing here changes, so the core output stays stable for capture.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_valid  <= 1'b0;
      r_op_id     <= '0;
      r_sq_r      <= '0;
      r_ptr       <= '0;
      r_grant_cnt <= '0;
    end else if (w_accept) begin
      r_op_valid  <= 1'b1;
      r_op_id     <= w_win;
      r_sq_r      <= w_win_data;
      r_ptr       <= w_ptr_next;
      r_grant_cnt <= r_grant_cnt + 32'd1;
    end else if (w_iss_adv) begin
      // Nothing to take: the stage empties but the radicand and pointer
      // keep their values.
      r_op_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Response stage: a capture takes priority over a plain drain, so a
  // handshake in the same cycle as a new capture leaves rsp_valid high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (r_op_valid && w_out_adv) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_op_id;
      r_rsp_data  <= sq_q;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sq_r      = r_sq_r;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rr_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_rr_share_ctrl
//  Purpose  : Self-checking bench for sqrt_rr_share_ctrl. An exact floor
//             integer square root stands in for the external core. Directed
//             scenarios cover reset, single request, round-robin order,
//             backpressure, fairness, mid-stream reset, boundaries and
//             counter wrap; a randomized run is compared against a
//             transaction-level queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_rr_share_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [15:0]       sq_r;
  logic [7:0]        sq_q;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [IW-1:0]     rsp_id;
  logic [31:0]       grant_cnt;

  int errors = 0;
  int checks = 0;

  sqrt_rr_share_ctrl #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sq_r      (sq_r),
    .sq_q      (sq_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Exact floor-sqrt core attached to the controller.
  always_comb sq_q = 8'(isqrt(int'(sq_r)));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    req_data[16*i +: 16] = v;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = {16'd100, 16'd81, 16'd64, 16'd49};
    rsp_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 8'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (sq_r !== 16'd0) begin errors++; $display("FAIL reset_sq_r: got %0d expected 0", sq_r); end
    checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL reset_grant_cnt: got %0d expected 0", grant_cnt); end
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    apply_reset();
    set_data(0, 16'd144);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
    checks++; if (sq_r !== 16'd144) begin errors++; $display("FAIL single_sq_r: got %0d expected 144", sq_r); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 8'd12) begin errors++; $display("FAIL single_rsp_data: got %0d expected 12", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (grant_cnt !== 32'd1) begin errors++; $display("FAIL single_grant_cnt: got %0d expected 1", grant_cnt); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drain: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 8'd12) begin errors++; $display("FAIL single_rsp_hold: got %0d expected 12", rsp_data); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin();
    int roots[4];
    roots = '{1, 2, 3, 255};
    apply_reset();
    req_data  = {16'd65535, 16'd9, 16'd4, 16'd1};
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected 1", c, rsp_valid); end
        checks++; if (rsp_data !== 8'(roots[(c - 2) % 4])) begin errors++; $display("FAIL rr_rsp_data c=%0d: got %0d expected %0d", c, rsp_data, roots[(c - 2) % 4]); end
        checks++; if (rsp_id !== 2'((c - 2) % 4)) begin errors++; $display("FAIL rr_rsp_id c=%0d: got %0d expected %0d", c, rsp_id, (c - 2) % 4); end
      end
      tick();
    end
    req_valid = '0;
    checks++; if (grant_cnt !== 32'd10) begin errors++; $display("FAIL rr_grant_cnt: got %0d expected 10", grant_cnt); end
    tick();
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    set_data(2, 16'd400);
    set_data(3, 16'd900);
    req_valid = 4'b1100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_second: got %b expected 1000", req_ready); end
    tick();
    set_data(1, 16'd49);
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready c=%0d: got %b expected 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd20 || rsp_id !== 2'd2) begin errors++; $display("FAIL bp_hold_rsp c=%0d: got v=%b d=%0d id=%0d expected v=1 d=20 id=2", c, rsp_valid, rsp_data, rsp_id); end
      checks++; if (sq_r !== 16'd900) begin errors++; $display("FAIL bp_hold_sq_r c=%0d: got %0d expected 900", c, sq_r); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd30 || rsp_id !== 2'd3) begin errors++; $display("FAIL bp_second_rsp: got v=%b d=%0d id=%0d expected v=1 d=30 id=3", rsp_valid, rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd7 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_third_rsp: got v=%b d=%0d id=%0d expected v=1 d=7 id=1", rsp_valid, rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", rsp_valid); end
    checks++; if (grant_cnt !== 32'd3) begin errors++; $display("FAIL bp_grant_cnt: got %0d expected 3", grant_cnt); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fairness_gap();
    apply_reset();
    set_data(1, 16'd25);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_first: got %b expected 0010", req_ready); end
    tick();
    set_data(0, 16'd36);
    set_data(1, 16'd64);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_wrap: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_third: got %b expected 0010", req_ready); end
    checks++; if (rsp_data !== 8'd5 || rsp_id !== 2'd1) begin errors++; $display("FAIL fair_rsp1: got d=%0d id=%0d expected d=5 id=1", rsp_data, rsp_id); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_data !== 8'd6 || rsp_id !== 2'd0) begin errors++; $display("FAIL fair_rsp2: got d=%0d id=%0d expected d=6 id=0", rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd8 || rsp_id !== 2'd1) begin errors++; $display("FAIL fair_rsp3: got v=%b d=%0d id=%0d expected v=1 d=8 id=1", rsp_valid, rsp_data, rsp_id); end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midstream();
    apply_reset();
    rsp_ready = 1'b0;
    req_data  = {16'd10000, 16'd121, 16'd16, 16'd1};
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1100;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_full_ready: got %b expected 0000", req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL mid_grant_cnt: got %0d expected 0", grant_cnt); end
    checks++; if (sq_r !== 16'd0) begin errors++; $display("FAIL mid_sq_r: got %0d expected 0", sq_r); end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    // Pointer back at 0: requester 1 wins over 3.
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr_zero: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_req3_ready: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd4 || rsp_id !== 2'd1) begin errors++; $display("FAIL mid_rsp_a: got v=%b d=%0d id=%0d expected v=1 d=4 id=1", rsp_valid, rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd100 || rsp_id !== 2'd3) begin errors++; $display("FAIL mid_rsp_b: got v=%b d=%0d id=%0d expected v=1 d=100 id=3", rsp_valid, rsp_data, rsp_id); end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_boundaries();
    apply_reset();
    set_data(0, 16'd0);
    set_data(1, 16'd65535);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL bnd_zero: got v=%b d=%0d id=%0d expected v=1 d=0 id=0", rsp_valid, rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd255 || rsp_id !== 2'd1) begin errors++; $display("FAIL bnd_max: got v=%b d=%0d id=%0d expected v=1 d=255 id=1", rsp_valid, rsp_data, rsp_id); end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_cnt_wrap();
    apply_reset();
    force dut.r_grant_cnt = 32'hFFFF_FFFE;
    #2;
    release dut.r_grant_cnt;
    @(negedge clk);
    set_data(0, 16'd1);
    set_data(1, 16'd1);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (grant_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffffffff", grant_cnt); end
    tick();
    req_valid = '0;
    checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", grant_cnt); end
    tick();
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Randomized traffic against a queue model: entries in flight are kept
  // oldest-first; rsp_full says whether the oldest one is visible on rsp_*.
  // --------------------------------------------------------------------------
  task automatic test_random();
    bit          v[N];
    logic [15:0] d[N];
    int          qid[$];
    int          qroot[$];
    int          mptr;
    logic [31:0] mcnt;
    bit          rsp_full;
    bit          issue_full, out_adv, iss_adv, found;
    int          w, idx;
    logic [N-1:0] exp_ready;

    apply_reset();
    mptr     = 0;
    mcnt     = 0;
    rsp_full = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = 0;
      d[i] = '0;
    end

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1;
          case ($urandom_range(0, 7))
            0:       d[i] = 16'd0;
            1:       d[i] = 16'd65535;
            default: d[i] = 16'($urandom);
          endcase
        end
        req_valid[i] = v[i];
        set_data(i, d[i]);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;

      issue_full = ((qid.size() - int'(rsp_full)) == 1);
      out_adv    = !rsp_full || rsp_ready;
      iss_adv    = !issue_full || out_adv;
      found      = 0;
      w          = 0;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (!found && v[idx]) begin
          found = 1;
          w     = idx;
        end
      end
      exp_ready = (found && iss_adv) ? N'(1 << w) : '0;

      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, req_ready, exp_ready); end
      checks++; if (rsp_valid !== rsp_full) begin errors++; $display("FAIL rnd_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, rsp_full); end
      if (rsp_full) begin
        checks++; if (rsp_data !== 8'(qroot[0]) || rsp_id !== IW'(qid[0])) begin errors++; $display("FAIL rnd_rsp c=%0d: got d=%0d id=%0d expected d=%0d id=%0d", c, rsp_data, rsp_id, qroot[0], qid[0]); end
      end
      checks++; if (grant_cnt !== mcnt) begin errors++; $display("FAIL rnd_grant_cnt c=%0d: got %0d expected %0d", c, grant_cnt, mcnt); end

      @(posedge clk);
      if (rsp_full && rsp_ready) begin
        void'(qid.pop_front());
        void'(qroot.pop_front());
        rsp_full = 0;
      end
      if (issue_full && out_adv) rsp_full = 1;
      if (found && iss_adv) begin
        qid.push_back(w);
        qroot.push_back(isqrt(int'(d[w])));
        mptr = (w + 1) % N;
        mcnt = mcnt + 32'd1;
        v[w] = 0;
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness_gap();
    test_reset_midstream();
    test_boundaries();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
